wave_capture: RTL and testbench
===============================

WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 SAMPLE_W, default 16: width of the incoming signed audio sample; must be at least 8.
REQ-002 clk  in  1: single system clock; all state changes on its rising edge.
REQ-003 reset  in  1: synchronous, active-low reset (0 = reset), sampled on clk rising edge.
REQ-004 new_sample_ready  in  1: one-cycle strobe marking new_sample_in valid.
REQ-005 new_sample_in  in  SAMPLE_W: signed two's-complement audio sample.
REQ-006 wave_display_idle  in  1: high while the display is outside the visible area and not reading sample RAM.
REQ-007 write_address  out  9: sample RAM write address, {capture half, 8-bit index}.
REQ-008 write_enable  out  1: one-cycle RAM write strobe.
REQ-009 write_sample  out  8: offset-binary sample written to RAM.
REQ-010 read_index  out  1: RAM half the display reads; the capture writes the other half.

Function
REQ-011 The FSM shall have three states: ARMED, ACTIVE and WAIT.
REQ-012 prev_sample shall load new_sample_in on every new_sample_ready, in every state.
REQ-013 A trigger is a positive zero crossing: prev_sample MSB = 1 and new_sample_in MSB = 0, evaluated on a new_sample_ready cycle.
REQ-014 ARMED with new_sample_ready and trigger: write the triggering sample at index 0, set count to 1, go to ACTIVE.
REQ-015 ARMED without trigger: no write, stay ARMED.
REQ-016 ACTIVE with new_sample_ready: write the sample at index count, then increment count.
REQ-017 ACTIVE, write at index 255: go to WAIT; count wraps to 0.
REQ-018 ACTIVE without new_sample_ready: hold state and count, no write.
REQ-019 WAIT with wave_display_idle = 1: toggle read_index and go to ARMED in the same edge.
REQ-020 WAIT with wave_display_idle = 0: hold.
REQ-021 WAIT shall never write and shall never trigger, even if new_sample_ready arrives; prev_sample still updates per REQ-012.
REQ-022 wave_display_idle shall be ignored in ARMED and ACTIVE.
REQ-023 Trigger evaluation shall use the state before the edge: a sample arriving on the WAIT-to-ARMED edge is not a trigger candidate.
REQ-024 Write outputs shall be registered, with 1-cycle latency:
- write_enable is high in the cycle after the qualifying new_sample_ready edge, for exactly one cycle.
- In that cycle, write_address = {~read_index, index} and write_sample holds the corresponding data.
REQ-025 write_sample = new_sample_in[SAMPLE_W-1:SAMPLE_W-8] with the MSB inverted (signed to offset binary; -32768 maps to 0x00, 0 to 0x80, 32767 to 0xFF).
REQ-026 write_address and write_sample shall hold their last values while write_enable = 0.
REQ-027 Exactly 256 writes shall occur per capture, at indices 0..255 in order, all to the half opposite read_index.
REQ-028 read_index shall change only on the WAIT-to-ARMED transition.

Reset
REQ-029 While reset = 0 at a clock edge, the block shall reset to:
- state ARMED, count 0, prev_sample 0
- read_index 0, write_enable 0, write_address 0, write_sample 0
REQ-030 Reset mid-capture shall abandon the capture with no further writes; the first post-reset capture writes to half 1 (addresses 256..511).
REQ-031 Because prev_sample resets to 0, the first sample after reset shall never trigger.

Verification
REQ-032 Reset, then samples -5, +3 -> trigger on +3; one cycle later write_enable = 1, write_address = 0x100, write_sample = 0x80.
REQ-033 After the trigger, 255 further samples with wave_display_idle = 0 -> 256 writes total, at addresses 0x100..0x1FF, then state WAIT; additional new_sample_ready strobes produce no write.
REQ-034 In WAIT, pulse wave_display_idle = 1 for one cycle -> read_index becomes 1; the next capture writes to 0x000..0x0FF.
REQ-035 Monotonically rising samples from 0 with no negative values -> no trigger and write_enable stays 0; then -1 followed by 0 -> trigger on 0.
REQ-036 Assert reset = 0 after 100 captured samples -> all outputs return to reset values and the next capture starts at 0x100 only after a fresh crossing.
REQ-037 Offset conversion: inputs 0x8000, 0x7FFF and 0xFF00 written in ACTIVE -> write_sample = 0x00, 0xFF and 0x7F respectively.

Source files
------------

// File: rtl/wave_capture.sv
// Triggered waveform capture: records 256 samples after each positive zero crossing
// into the RAM half the display is not reading, then waits for the display to go idle.
module wave_capture #(
   parameter int SAMPLE_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                new_sample_ready,
   input  logic [SAMPLE_W-1:0] new_sample_in,
   input  logic                wave_display_idle,
   output logic [8:0]          write_address,
   output logic                write_enable,
   output logic [7:0]          write_sample,
   output logic                read_index
);

   typedef enum logic [1:0] {
      ARMED  = 2'd0,
      ACTIVE = 2'd1,
      WAIT   = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] count_q, count_d;
   logic       prev_sign_q, prev_sign_d;
   logic       read_index_q, read_index_d;
   logic       write_enable_q, write_enable_d;
   logic [8:0] write_address_q, write_address_d;
   logic [7:0] write_sample_q, write_sample_d;

   logic       trigger;
   logic [7:0] offset_sample;

   // Only the sign of the previous sample matters for crossing detection,
   // so that is all that is kept of it.
   assign trigger       = prev_sign_q & ~new_sample_in[SAMPLE_W-1];
   assign offset_sample = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2:SAMPLE_W-8]};

   generate
      if (SAMPLE_W > 8) begin : g_low_bits
         logic unused_low_bits;
         assign unused_low_bits = ^new_sample_in[SAMPLE_W-9:0];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q         <= ARMED;
         count_q         <= 8'd0;
         prev_sign_q     <= 1'b0;
         read_index_q    <= 1'b0;
         write_enable_q  <= 1'b0;
         write_address_q <= 9'd0;
         write_sample_q  <= 8'd0;
      end else begin
         state_q         <= state_d;
         count_q         <= count_d;
         prev_sign_q     <= prev_sign_d;
         read_index_q    <= read_index_d;
         write_enable_q  <= write_enable_d;
         write_address_q <= write_address_d;
         write_sample_q  <= write_sample_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      count_d         = count_q;
      prev_sign_d     = prev_sign_q;
      read_index_d    = read_index_q;
      write_enable_d  = 1'b0;
      write_address_d = write_address_q;
      write_sample_d  = write_sample_q;

      if (new_sample_ready) begin
         prev_sign_d = new_sample_in[SAMPLE_W-1];
      end

      case (state_q)
         ARMED: begin
            if (new_sample_ready && trigger) begin
               write_enable_d  = 1'b1;
               write_address_d = {~read_index_q, 8'd0};
               write_sample_d  = offset_sample;
               count_d         = 8'd1;
               state_d         = ACTIVE;
            end
         end
         ACTIVE: begin
            if (new_sample_ready) begin
               write_enable_d  = 1'b1;
               write_address_d = {~read_index_q, count_q};
               write_sample_d  = offset_sample;
               count_d         = count_q + 8'd1;
               if (count_q == 8'd255) begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            // Swap halves only while the display is not reading the RAM.
            if (wave_display_idle) begin
               read_index_d = ~read_index_q;
               state_d      = ARMED;
            end
         end
         default: begin
            state_d = ARMED;
         end
      endcase
   end

   assign write_address = write_address_q;
   assign write_enable  = write_enable_q;
   assign write_sample  = write_sample_q;
   assign read_index    = read_index_q;

endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture: expected RAM writes are queued as samples are
// driven and popped by a monitor whenever the design strobes write_enable.
module tb_wave_capture;

   logic        clk = 1'b0;
   logic        reset;
   logic        new_sample_ready;
   logic [15:0] new_sample_in;
   logic        wave_display_idle;
   logic [8:0]  write_address;
   logic        write_enable;
   logic [7:0]  write_sample;
   logic        read_index;

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;

   logic [16:0] sb[$];

   wave_capture #(.SAMPLE_W(16)) dut (
      .clk               (clk),
      .reset             (reset),
      .new_sample_ready  (new_sample_ready),
      .new_sample_in     (new_sample_in),
      .wave_display_idle (wave_display_idle),
      .write_address     (write_address),
      .write_enable      (write_enable),
      .write_sample      (write_sample),
      .read_index        (read_index)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [8:0] addr, input logic [7:0] data);
      sb.push_back({addr, data});
   endtask

   task automatic send(input logic [15:0] s);
      new_sample_in    = s;
      new_sample_ready = 1'b1;
      @(posedge clk); #1;
      new_sample_ready = 1'b0;
   endtask

   task automatic gap(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain_check(input string tag);
      @(negedge clk); #1;
      check(tag, sb.size(), 0);
   endtask

   task automatic reset_check(input string tag);
      check({tag, "_we"},   write_enable,  0);
      check({tag, "_addr"}, write_address, 0);
      check({tag, "_data"}, write_sample,  0);
      check({tag, "_ridx"}, read_index,    0);
   endtask

   // Scoreboard consumer: every strobe must match the oldest queued write.
   always @(negedge clk) begin
      if (write_enable === 1'b1) begin
         $display("write addr=%03h data=%02h", write_address, write_sample);
         if (sb.size() == 0) begin
            check("spurious_write", write_enable, 0);
         end else begin
            logic [16:0] e;
            e = sb.pop_front();
            check("write_addr", write_address, e[16:8]);
            check("write_data", write_sample,  e[7:0]);
         end
      end
   end

   initial begin
      logic [15:0] s;
      reset             = 1'b0;
      new_sample_ready  = 1'b0;
      new_sample_in     = 16'h0000;
      wave_display_idle = 1'b0;
      gap(3);
      reset_check("por");
      reset = 1'b1;

      // First capture: -5 then +3 triggers, lands in half 1.
      send(16'hFFFB);
      push(9'h100, 8'h80);
      send(16'h0003);
      drain_check("first_trigger");

      push(9'h101, 8'h00); send(16'h8000);
      push(9'h102, 8'hFF); send(16'h7FFF);
      push(9'h103, 8'h7F); send(16'hFF00);
      for (int i = 4; i < 256; i++) begin
         s = 16'($urandom);
         push(9'(9'h100 + i), s[15:8] ^ 8'h80);
         send(s);
         if (i % 7 == 0) gap(2);
      end
      drain_check("capture1_done");
      check("ridx_active", read_index, 0);

      // WAIT: strobes and crossings must not write; busy display holds.
      send(16'hFFFF); send(16'h0001); send(16'hFFFF);
      gap(3);
      check("ridx_wait_hold", read_index, 0);

      // Release with a crossing on the same edge: must not trigger.
      wave_display_idle = 1'b1;
      new_sample_in     = 16'h0002;
      new_sample_ready  = 1'b1;
      @(posedge clk); #1;
      new_sample_ready  = 1'b0;
      wave_display_idle = 1'b0;
      check("ridx_toggle", read_index, 1);

      // ARMED ignores idle; rising non-negative samples never trigger.
      wave_display_idle = 1'b1;
      for (int v = 5; v <= 20; v++) send(16'(v));
      gap(2);
      check("ridx_armed_hold", read_index, 1);
      check("no_trigger_rising", sb.size(), 0);

      send(16'hFFFF);
      push(9'h000, 8'h80);
      send(16'h0000);
      for (int i = 1; i < 100; i++) begin
         s = 16'($urandom);
         push(9'(i), s[15:8] ^ 8'h80);
         send(s);
         wave_display_idle = ~wave_display_idle;
      end
      drain_check("capture2_partial");
      check("ridx_capture2", read_index, 1);

      // Reset mid-capture, with a sample strobe that must be ignored.
      reset             = 1'b0;
      wave_display_idle = 1'b0;
      new_sample_in     = 16'h0005;
      new_sample_ready  = 1'b1;
      @(posedge clk); #1;
      new_sample_ready  = 1'b0;
      gap(1);
      reset_check("mid_rst");
      reset = 1'b1;

      send(16'h0004);
      gap(2);
      check("no_write_after_rst", sb.size(), 0);
      send(16'hFFF0);
      push(9'h100, 8'h92); send(16'h1234);
      push(9'h101, 8'h00); send(16'h8001);
      drain_check("capture3_start");
      check("ridx_after_rst", read_index, 0);

      gap(2);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
